// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator for one synth voice: programmable per-phase ramp rates,
// prescaled step timing, retrigger, early release and a one-cycle done pulse.
module adsr_envelope_gen #(
  parameter int W     = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             note_on,
  input  logic             note_off,
  input  logic [W-1:0]     start_lvl,
  input  logic [W-1:0]     peak_lvl,
  input  logic [W-1:0]     sustain_lvl,
  input  logic [W-1:0]     end_lvl,
  input  logic [W-1:0]     atk_step,
  input  logic [W-1:0]     dec_step,
  input  logic [W-1:0]     rel_step,
  input  logic [DIV_W-1:0] tick_div,
  output logic [W-1:0]     level,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             done
);

  // state   | meaning
  // IDLE    | level follows start_lvl, waiting for note_on
  // ATTACK  | ramp up toward peak_lvl
  // DECAY   | ramp down toward sustain_lvl
  // SUSTAIN | level follows sustain_lvl until note_off
  // RELEASE | ramp down toward end_lvl, then done pulse
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic [W:0]       atk_sum;
  logic [W:0]       dec_lim;
  logic [W:0]       rel_lim;

  // One extra bit on every sum so large steps saturate at the target instead of wrapping.
  assign tick    = (cnt == tick_div);
  assign atk_sum = {1'b0, level} + {1'b0, atk_step};
  assign dec_lim = {1'b0, sustain_lvl} + {1'b0, dec_step};
  assign rel_lim = {1'b0, end_lvl} + {1'b0, rel_step};

  assign phase = state;
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
      level <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (note_on) begin
        // Retrigger keeps the current level so the new attack ramps from it.
        state <= S_ATTACK;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            level <= start_lvl;
          end
          S_ATTACK: begin
            if (note_off) begin
              state <= S_RELEASE;
              cnt   <= '0;
            end else if (tick) begin
              cnt <= '0;
              if (atk_step == '0 || atk_sum >= {1'b0, peak_lvl}) begin
                level <= peak_lvl;
                state <= S_DECAY;
              end else begin
                level <= atk_sum[W-1:0];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DECAY: begin
            if (note_off) begin
              state <= S_RELEASE;
              cnt   <= '0;
            end else if (tick) begin
              cnt <= '0;
              if (dec_step == '0 || {1'b0, level} <= dec_lim) begin
                level <= sustain_lvl;
                state <= S_SUSTAIN;
              end else begin
                level <= level - dec_step;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SUSTAIN: begin
            level <= sustain_lvl;
            if (note_off) begin
              state <= S_RELEASE;
              cnt   <= '0;
            end
          end
          S_RELEASE: begin
            if (tick) begin
              cnt <= '0;
              if (rel_step == '0 || {1'b0, level} <= rel_lim) begin
                level <= end_lvl;
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                level <= level - rel_step;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
